permutation_sequencer: RTL and testbench

Control block directly upstream of the permutation datapath. On a start request it drives the datapath's round index and input-select for one full Ascon permutation, either p^a (12 rounds) or p^b (6 rounds). It signals the single cycle in which the permuted state is valid on the datapath output. The mode FSMs (initialisation, associated data, plaintext, finalisation) invoke it once per permutation.

---
 rtl/ascon_pack.sv | 18 +
 rtl/round_counter.sv | 28 ++
 rtl/permutation_sequencer.sv | 77 +++++++
 tb/tb_permutation_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon permutation control path.
// The round index of the last permutation round is fixed; shorter permutations start later.
package ascon_pack;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } type_seq_state;

   localparam logic [3:0] ROUND_LAST = 4'd11;

   // Constant index of the first round, so a shortened permutation still ends on round 11.
   function automatic logic [3:0] first_round(input int unsigned rounds);
      return 4'(12 - rounds);
   endfunction

endpackage

// File: rtl/round_counter.sv
// Round index register for the permutation sequencer.
// A load takes priority over an increment.
module round_counter
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       load_i,
   input  logic [3:0] load_value_i,
   input  logic       inc_i,
   output logic [3:0] count_o
);

   logic [3:0] count_reg;

   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         count_reg <= 4'd0;
      end else if (load_i) begin
         count_reg <= load_value_i;
      end else if (inc_i) begin
         count_reg <= count_reg + 4'd1;
      end
   end

   assign count_o = count_reg;

endmodule

// File: rtl/permutation_sequencer.sv
// Drives round index and input select for one Ascon p^a / p^b permutation.
// All outputs are decoded from registered state only.
module permutation_sequencer
   import ascon_pack::*;
#(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       mode_i,
   output logic       ready_o,
   output logic       busy_o,
   output logic [3:0] round_o,
   output logic       input_select_o,
   output logic       done_o
);

   localparam logic [3:0] FIRST_A = first_round(ROUNDS_A);
   localparam logic [3:0] FIRST_B = first_round(ROUNDS_B);

   type_seq_state state_reg, state_next;
   logic          first_reg;
   logic          accept;
   logic          inc;
   logic [3:0]    count;
   logic [3:0]    load_value;

   assign accept     = (state_reg != RUN) && start_i;
   assign load_value = mode_i ? FIRST_B : FIRST_A;

   round_counter u_round_counter (
      .clock_i      (clock_i),
      .resetb_i     (resetb_i),
      .load_i       (accept),
      .load_value_i (load_value),
      .inc_i        (inc),
      .count_o      (count)
   );

   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         state_reg <= IDLE;
         first_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         first_reg <= accept;
      end
   end

   always_comb begin
      state_next = state_reg;
      inc        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i) state_next = RUN;
         end
         RUN: begin
            if (count == ROUND_LAST) state_next = DONE;
            else                     inc        = 1'b1;
         end
         DONE: begin
            // A start in the done cycle chains straight into the next permutation.
            state_next = start_i ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ready_o        = (state_reg != RUN);
   assign busy_o         = (state_reg == RUN);
   assign done_o         = (state_reg == DONE);
   assign round_o        = (state_reg == RUN) ? count : 4'd0;
   assign input_select_o = (state_reg == RUN) && !first_reg;

endmodule

// File: tb/tb_permutation_sequencer.sv
// Scoreboard bench for permutation_sequencer: expected per-cycle outputs are queued
// as stimulus is driven and compared just after each rising edge.
module tb_permutation_sequencer;

   localparam int RA = 12;
   localparam int RB = 6;

   logic       clk = 1'b0;
   logic       resetb;
   logic       start;
   logic       mode;
   logic       ready;
   logic       busy;
   logic [3:0] round;
   logic       isel;
   logic       done;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   permutation_sequencer #(
      .ROUNDS_A (RA),
      .ROUNDS_B (RB)
   ) dut (
      .clock_i        (clk),
      .resetb_i       (resetb),
      .start_i        (start),
      .mode_i         (mode),
      .ready_o        (ready),
      .busy_o         (busy),
      .round_o        (round),
      .input_select_o (isel),
      .done_o         (done)
   );

   // Packed view: {ready, busy, round[3:0], input_select, done}
   function automatic logic [7:0] observed();
      return {ready, busy, round, isel, done};
   endfunction

   function automatic void push_idle();
      exp_q.push_back({1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
   endfunction

   function automatic void push_done();
      exp_q.push_back({1'b1, 1'b0, 4'd0, 1'b0, 1'b1});
   endfunction

   // RUN cycles for rounds lo..hi of a permutation whose first round is first.
   function automatic void push_rounds(input int first, input int lo, input int hi);
      for (int r = lo; r <= hi; r++) begin
         logic [3:0] r4;
         r4 = 4'(r);
         exp_q.push_back({1'b0, 1'b1, r4, (r != first), 1'b0});
      end
   endfunction

   function automatic void push_perm(input int rounds);
      push_rounds(12 - rounds, 12 - rounds, 11);
      push_done();
   endfunction

   task automatic test_reset();
      logic [7:0] obs, expv;
      for (int i = 0; i < 5; i++) begin
         resetb = (i >= 3);
         start  = 1'b0;
         mode   = 1'b0;
         push_idle();
         @(posedge clk); #1;
         obs = observed();
         expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         vectors++;
         if (obs !== expv) begin
            $display("FAIL test_reset cycle %0d: got %h expected %h", i, obs, expv);
            miscompares++;
         end
      end
   endtask

   // Single permutation with mode_i wiggled during RUN (must be ignored).
   task automatic test_perm(input logic m, input int rounds, input string name);
      logic [7:0] obs, expv;
      int         busy_cycles;
      busy_cycles = 0;
      for (int i = 0; i < rounds + 3; i++) begin
         start = (i == 0);
         mode  = (i == 0) ? m : 1'($urandom_range(0, 1));
         if (i == 0) push_perm(rounds);
         if (i >= rounds + 1) push_idle();
         @(posedge clk); #1;
         obs = observed();
         if (busy) busy_cycles++;
         expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         vectors++;
         if (obs !== expv) begin
            $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, expv);
            miscompares++;
         end
      end
      vectors++;
      if (busy_cycles !== rounds) begin
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, rounds);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] obs, expv;
      for (int i = 0; i < RA + RB + 3; i++) begin
         start = (i == 0) || (i == RA + 1);
         mode  = (i == RA + 1);
         if (i == 0) push_perm(RA);
         if (i == RA + 1) push_perm(RB);
         if (i >= RA + RB + 2) push_idle();
         @(posedge clk); #1;
         obs = observed();
         expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         vectors++;
         if (obs !== expv) begin
            $display("FAIL test_back_to_back cycle %0d: got %h expected %h", i, obs, expv);
            miscompares++;
         end
      end
   endtask

   // start_i pulsed in the cycle showing round 4 must not disturb the run.
   task automatic test_start_during_run();
      logic [7:0] obs, expv;
      for (int i = 0; i < RA + 3; i++) begin
         start = (i == 0) || (i == 5);
         mode  = (i == 5);
         if (i == 0) push_perm(RA);
         if (i >= RA + 1) push_idle();
         @(posedge clk); #1;
         obs = observed();
         expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         vectors++;
         if (obs !== expv) begin
            $display("FAIL test_start_during_run cycle %0d: got %h expected %h", i, obs, expv);
            miscompares++;
         end
      end
   endtask

   // Reset applied while round 8 is shown aborts the run with no done pulse.
   task automatic test_reset_mid_run();
      logic [7:0] obs, expv;
      for (int i = 0; i < RA + 6; i++) begin
         start  = (i == 0);
         mode   = 1'b0;
         resetb = (i != 9);
         if (i == 0) push_rounds(0, 0, 8);
         if (i >= 9) push_idle();
         @(posedge clk); #1;
         obs = observed();
         expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         vectors++;
         if (obs !== expv) begin
            $display("FAIL test_reset_mid_run cycle %0d: got %h expected %h", i, obs, expv);
            miscompares++;
         end
      end
      resetb = 1'b1;
   endtask

   initial begin
      resetb = 1'b0;
      start  = 1'b0;
      mode   = 1'b0;
      test_reset();
      test_perm(1'b0, RA, "test_pa");
      test_perm(1'b1, RB, "test_pb");
      test_back_to_back();
      test_start_during_run();
      test_reset_mid_run();
      vectors++;
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
